// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S defaults and frame/slot helpers for TX and RX
package i2s_pkg;

    localparam int DATA_W_DEF     = 16;
    localparam int SLOT_W_DEF     = 32;
    localparam int BCLK_DIV_DEF   = 8;
    localparam int FRAME_BITS_DEF = 2 * SLOT_W_DEF;

    // BCLK periods in one stereo frame (left slot + right slot)
    function automatic int frame_bits(input int slot_w);
        return 2 * slot_w;
    endfunction

    // Position of a frame bit inside its channel slot; 0 is the one-bit I2S delay slot
    function automatic int slot_pos(input int bit_idx, input int slot_w);
        return (bit_idx >= slot_w) ? bit_idx - slot_w : bit_idx;
    endfunction

endpackage

// File: rtl/i2s_transmit_master_if.sv
// rtl/i2s_transmit_master_if.sv - stereo sample valid/ready handshake bundle
interface i2s_transmit_master_if #(
    parameter int DATA_W = 16
) ();

    logic              in_valid;
    logic [DATA_W-1:0] in_left;
    logic [DATA_W-1:0] in_right;
    logic              in_ready;

    modport master (
        output in_valid,
        output in_left,
        output in_right,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_left,
        input  in_right,
        output in_ready
    );

endinterface

// File: rtl/i2s_clk_gen.sv
// rtl/i2s_clk_gen.sv - BCLK/LRCLK generator with rise/fall ticks and frame bit counter
module i2s_clk_gen
    import i2s_pkg::*;
#(
    parameter  int SLOT_W     = SLOT_W_DEF,
    parameter  int BCLK_DIV   = BCLK_DIV_DEF,
    localparam int FRAME_BITS = frame_bits(SLOT_W),
    localparam int CW         = $clog2(BCLK_DIV),
    localparam int BW         = $clog2(FRAME_BITS)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          bclk,
    output logic          lrclk,
    output logic          rise_tick,
    output logic          fall_tick,
    output logic          frame_wrap,
    output logic [BW-1:0] bit_cnt
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          bclk_q, bclk_d;
    logic          lrclk_q, lrclk_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic          cnt_last;

    assign cnt_last   = (cnt_q == CW'(BCLK_DIV - 1));
    assign rise_tick  = cnt_last & ~bclk_q;
    assign fall_tick  = cnt_last &  bclk_q;
    assign frame_wrap = fall_tick & (bit_cnt_q == BW'(FRAME_BITS - 1));

    assign bclk    = bclk_q;
    assign lrclk   = lrclk_q;
    assign bit_cnt = bit_cnt_q;

    // Half-period divider toggles BCLK; frame position and word select move on the falling edge
    always_comb begin
        cnt_d     = cnt_q;
        bclk_d    = bclk_q;
        lrclk_d   = lrclk_q;
        bit_cnt_d = bit_cnt_q;
        if (cnt_last) begin
            cnt_d  = '0;
            bclk_d = ~bclk_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        if (fall_tick) begin
            bit_cnt_d = frame_wrap ? '0 : bit_cnt_q + BW'(1);
            lrclk_d   = (int'(bit_cnt_d) >= SLOT_W);
        end
    end

    // Clock generator state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            bclk_q    <= 1'b0;
            lrclk_q   <= 1'b0;
            bit_cnt_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            bclk_q    <= bclk_d;
            lrclk_q   <= lrclk_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/i2s_transmit_master.sv
// rtl/i2s_transmit_master.sv - I2S master transmitter, Philips timing; option macro I2S_TX_MUTE_ON_UNDERFLOW_EN
module i2s_transmit_master
    import i2s_pkg::*;
#(
    parameter  int DATA_W     = DATA_W_DEF,
    parameter  int SLOT_W     = SLOT_W_DEF,
    parameter  int BCLK_DIV   = BCLK_DIV_DEF,
    localparam int FRAME_BITS = frame_bits(SLOT_W),
    localparam int BW         = $clog2(FRAME_BITS),
    localparam int IW         = $clog2(DATA_W)
) (
    input  logic                  CLOCK_50,
    input  logic                  reset_n,
    i2s_transmit_master_if.slave  s_if,
    output logic                  i2s_bclk,
    output logic                  i2s_lrclk,
    output logic                  i2s_sd,
    output logic                  frame_start,
    output logic                  underflow
);

    logic          rise_tick;
    logic          fall_tick;
    logic          frame_wrap;
    logic [BW-1:0] bit_cnt;

    i2s_clk_gen #(
        .SLOT_W   (SLOT_W),
        .BCLK_DIV (BCLK_DIV)
    ) u_clk_gen (
        .clk        (CLOCK_50),
        .rst_n      (reset_n),
        .bclk       (i2s_bclk),
        .lrclk      (i2s_lrclk),
        .rise_tick  (rise_tick),
        .fall_tick  (fall_tick),
        .frame_wrap (frame_wrap),
        .bit_cnt    (bit_cnt)
    );

    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] hold_l_q, hold_l_d;
    logic [DATA_W-1:0] hold_r_q, hold_r_d;
    logic [DATA_W-1:0] act_l_q, act_l_d;
    logic [DATA_W-1:0] act_r_q, act_r_d;
    logic              sd_pre_q, sd_pre_d;
    logic              sd_q, sd_d;
    logic              frame_start_q, frame_start_d;
    logic              underflow_q, underflow_d;
    logic              accept;

    logic [BW-1:0]     next_bit;
    int                next_pos;
    logic [DATA_W-1:0] next_word;
    logic              next_sd;

    assign accept        = s_if.in_valid & ~hold_full_q;
    assign s_if.in_ready = ~hold_full_q;
    assign i2s_sd        = sd_q;
    assign frame_start   = frame_start_q;
    assign underflow     = underflow_q;

    // Data bit for the frame position that the next BCLK fall will present
    always_comb begin
        next_bit  = (bit_cnt == BW'(FRAME_BITS - 1)) ? '0 : bit_cnt + BW'(1);
        next_pos  = slot_pos(int'(next_bit), SLOT_W);
        next_word = (int'(next_bit) >= SLOT_W) ? act_r_q : act_l_q;
        next_sd   = 1'b0;
        if ((next_pos >= 1) && (next_pos <= DATA_W)) begin
            next_sd = next_word[IW'(DATA_W - next_pos)];
        end
    end

    // Holding/active registers, frame pulses and serial data staging
    always_comb begin
        hold_full_d   = hold_full_q;
        hold_l_d      = hold_l_q;
        hold_r_d      = hold_r_q;
        act_l_d       = act_l_q;
        act_r_d       = act_r_q;
        sd_pre_d      = sd_pre_q;
        sd_d          = sd_q;
        frame_start_d = frame_wrap;
        underflow_d   = frame_wrap & ~hold_full_q;

        if (frame_wrap) begin
            if (hold_full_q) begin
                act_l_d = hold_l_q;
                act_r_d = hold_r_q;
            end else begin
`ifdef I2S_TX_MUTE_ON_UNDERFLOW_EN
                act_l_d = '0;
                act_r_d = '0;
`else
                act_l_d = act_l_q;
                act_r_d = act_r_q;
`endif
            end
            hold_full_d = 1'b0;
        end

        // A pair accepted in the load cycle lands after the old contents moved out
        if (accept) begin
            hold_l_d    = s_if.in_left;
            hold_r_d    = s_if.in_right;
            hold_full_d = 1'b1;
        end

        // Bit is picked half a BCLK early so the fall edge only moves a flop to the pin
        if (rise_tick) begin
            sd_pre_d = next_sd;
        end
        if (fall_tick) begin
            sd_d = sd_pre_q;
        end
    end

    // Transmitter state
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            hold_full_q   <= 1'b0;
            hold_l_q      <= '0;
            hold_r_q      <= '0;
            act_l_q       <= '0;
            act_r_q       <= '0;
            sd_pre_q      <= 1'b0;
            sd_q          <= 1'b0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            hold_full_q   <= hold_full_d;
            hold_l_q      <= hold_l_d;
            hold_r_q      <= hold_r_d;
            act_l_q       <= act_l_d;
            act_r_q       <= act_r_d;
            sd_pre_q      <= sd_pre_d;
            sd_q          <= sd_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

endmodule

// File: tb/tb_i2s_transmit_master.sv
// tb/tb_i2s_transmit_master.sv - randomized bench with frame-level reference model and I2S receiver
module tb_i2s_transmit_master;

    localparam int DATA_W     = 16;
    localparam int SLOT_W     = 32;
    localparam int BCLK_DIV   = 2;
    localparam int FRAME_CLKS = 2 * BCLK_DIV * 2 * SLOT_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic i2s_bclk, i2s_lrclk, i2s_sd, frame_start, underflow;

    i2s_transmit_master_if #(.DATA_W(DATA_W)) bus ();

    i2s_transmit_master #(
        .DATA_W   (DATA_W),
        .SLOT_W   (SLOT_W),
        .BCLK_DIV (BCLK_DIV)
    ) dut (
        .CLOCK_50    (clk),
        .reset_n     (rst_n),
        .s_if        (bus),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrclk   (i2s_lrclk),
        .i2s_sd      (i2s_sd),
        .frame_start (frame_start),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model: clocks since reset release, holding slot, pair on the wire
    int          edge_n;
    logic        m_full;
    logic [15:0] m_hl, m_hr, m_l, m_r;
    logic        last_acc;
    logic        last_uf;
    logic [31:0] exp_q[$];

    // receiver model
    logic        rx_bclk_prev, rx_lr_prev;
    int          rx_pos;
    logic [15:0] rx_word, rx_l;
    logic [31:0] rx_last;
    int          n_rx = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        edge_n   = 0;
        m_full   = 1'b0;
        m_hl     = '0;
        m_hr     = '0;
        m_l      = '0;
        m_r      = '0;
        last_acc = 1'b0;
        last_uf  = 1'b0;
        exp_q.delete();
        exp_q.push_back(32'h0);
        rx_bclk_prev = 1'b0;
        rx_lr_prev   = 1'b1;
        rx_pos       = 0;
        rx_word      = '0;
        rx_l         = '0;
        rx_last      = '0;
    endtask

    task automatic rx_sample();
        logic [31:0] e;
        if (i2s_bclk && !rx_bclk_prev) begin
            if (i2s_lrclk != rx_lr_prev) rx_pos = 0;
            else rx_pos++;
            rx_lr_prev = i2s_lrclk;
            if (rx_pos >= 1 && rx_pos <= DATA_W) rx_word = {rx_word[14:0], i2s_sd};
            if (rx_pos == DATA_W) begin
                if (!i2s_lrclk) begin
                    rx_l = rx_word;
                end else begin
                    rx_last = {rx_l, rx_word};
                    n_rx++;
                    check_val("rx_have_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check_val("rx_pair", rx_last, e);
                    end
                end
            end
        end
        rx_bclk_prev = i2s_bclk;
    endtask

    task automatic tick();
        logic        load, acc, exp_sd;
        int          b, p;
        logic [15:0] w;
        @(posedge clk);
        edge_n++;
        load    = ((edge_n % FRAME_CLKS) == 0);
        acc     = bus.in_valid && !m_full;
        last_uf = 1'b0;
        if (load) begin
            last_uf = !m_full;
            if (m_full) begin
                m_l = m_hl;
                m_r = m_hr;
            end else begin
`ifdef I2S_TX_MUTE_ON_UNDERFLOW_EN
                m_l = '0;
                m_r = '0;
`endif
            end
            m_full = 1'b0;
            exp_q.push_back({m_l, m_r});
        end
        if (acc) begin
            m_hl   = bus.in_left;
            m_hr   = bus.in_right;
            m_full = 1'b1;
        end
        last_acc = acc;
        #1;
        b = (edge_n / (2 * BCLK_DIV)) % (2 * SLOT_W);
        p = b % SLOT_W;
        w = (b < SLOT_W) ? m_l : m_r;
        exp_sd = (p >= 1 && p <= DATA_W) ? w[DATA_W-p] : 1'b0;
        check_val("bclk", i2s_bclk, (edge_n / BCLK_DIV) % 2);
        check_val("lrclk", i2s_lrclk, b >= SLOT_W);
        check_val("sd", i2s_sd, exp_sd);
        check_val("in_ready", bus.in_ready, !m_full);
        check_val("frame_start", frame_start, load);
        check_val("underflow", underflow, last_uf);
        rx_sample();
    endtask

    task automatic run_to(input int target);
        while (edge_n < target) tick();
    endtask

    // offer a pair until the model holding slot takes it; returns the accept clock
    task automatic push(input logic [15:0] l, input logic [15:0] r, output int acc_edge);
        int n;
        n = 0;
        while (m_full && n < 2 * FRAME_CLKS) begin
            tick();
            n++;
        end
        check_val("push_wait_bound", m_full, 0);
        bus.in_valid = 1'b1;
        bus.in_left  = l;
        bus.in_right = r;
        tick();
        bus.in_valid = 1'b0;
        bus.in_left  = 16'($urandom);
        bus.in_right = 16'($urandom);
        acc_edge = edge_n;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_bclk"}, i2s_bclk, 0);
        check_val({tag, "_lrclk"}, i2s_lrclk, 0);
        check_val({tag, "_sd"}, i2s_sd, 0);
        check_val({tag, "_in_ready"}, bus.in_ready, 1);
        check_val({tag, "_frame_start"}, frame_start, 0);
        check_val({tag, "_underflow"}, underflow, 0);
    endtask

    initial begin
        int          ae, n;
        logic [31:0] pq[$];
        int          acc_frames[$];
        logic [15:0] rl, rr;

        bus.in_valid = 1'b0;
        bus.in_left  = '0;
        bus.in_right = '0;
        model_reset();

        // 1: reset values, then clock shapes checked every cycle by tick()
        #23;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // 2: known pair before the first wrap
        repeat (10) tick();
        push(16'hA5C3, 16'h8001, ae);
        run_to((ae / FRAME_CLKS + 1) * FRAME_CLKS + 220);
        check_val("t2_rx_pair", rx_last, 32'hA5C38001);

        // 3: starve the holding register
        run_to(edge_n + 2 * FRAME_CLKS);
`ifdef I2S_TX_MUTE_ON_UNDERFLOW_EN
        check_val("t3_rx_underflow", rx_last, 32'h0);
`else
        check_val("t3_rx_underflow", rx_last, 32'hA5C38001);
`endif

        // 4: in_valid held with three queued pairs
        for (int i = 0; i < 3; i++) pq.push_back($urandom);
        bus.in_valid = 1'b1;
        {bus.in_left, bus.in_right} = pq[0];
        n = 0;
        while (pq.size() > 0 && n < 5 * FRAME_CLKS) begin
            tick();
            n++;
            if (last_acc) begin
                acc_frames.push_back(edge_n / FRAME_CLKS);
                void'(pq.pop_front());
                if (pq.size() > 0) {bus.in_left, bus.in_right} = pq[0];
                else bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        check_val("t4_acc_count", acc_frames.size(), 3);
        for (int i = 1; i < acc_frames.size(); i++)
            check_val("t4_one_per_frame", acc_frames[i] - acc_frames[i-1], 1);
        run_to((edge_n / FRAME_CLKS + 2) * FRAME_CLKS + 10);
        // offer a pair exactly on a load cycle with the holding register empty
        while (((edge_n + 1) % FRAME_CLKS) != 0) tick();
        bus.in_valid = 1'b1;
        bus.in_left  = 16'h1234;
        bus.in_right = 16'hFEDC;
        tick();
        bus.in_valid = 1'b0;
        check_val("t4_load_accept_same", last_acc && last_uf, 1);
        run_to(edge_n + FRAME_CLKS + 220);
        check_val("t4_load_accept_pair", rx_last, 32'h1234FEDC);

        // 5: asynchronous reset at bit 40
        n = 0;
        while (((edge_n / (2 * BCLK_DIV)) % (2 * SLOT_W)) != 40 && n < FRAME_CLKS) begin
            tick();
            n++;
        end
        check_val("t5_reached_bit40", n < FRAME_CLKS, 1);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("t5_async");
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("t5_held");
        rst_n = 1'b1;
        model_reset();
        rl = 16'($urandom);
        rr = 16'($urandom);
        repeat (5) tick();
        push(rl, rr, ae);
        run_to((ae / FRAME_CLKS + 1) * FRAME_CLKS + 220);
        check_val("t5_rx_pair", rx_last, {rl, rr});

        // 6: full-scale pair
        push(16'h7FFF, 16'h8000, ae);
        run_to((ae / FRAME_CLKS + 1) * FRAME_CLKS + 220);
        check_val("t6_rx_pair", rx_last, 32'h7FFF8000);

        check_val("rx_pairs_seen", n_rx >= 10, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
